// File: rtl/can_pkg.sv
// Shared constants, state encoding and the CRC-15 step function for the CAN CRC path.
package can_pkg;

  localparam int               CAN_CRC_LEN  = 15;
  localparam logic [14:0]      CAN_CRC_POLY = 15'h4599;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCUM     = 2'd1,
    ST_CRC_FIELD = 2'd2,
    ST_DELIM     = 2'd3
  } crc_state_e;

  // One bit of the CAN CRC-15: feedback is the incoming bit xor the register MSB.
  function automatic logic [CAN_CRC_LEN-1:0] crc15_step(input logic [CAN_CRC_LEN-1:0] crc,
                                                        input logic                   din);
    logic fb;
    fb = din ^ crc[CAN_CRC_LEN-1];
    crc15_step = {crc[CAN_CRC_LEN-2:0], 1'b0} ^ (fb ? CAN_CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/can_crc.sv
// CRC-15 LFSR with synchronous clear; also exposes the value it will hold after this edge.
module can_crc
  import can_pkg::*;
(
  input  logic                   clock,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic                   din_i,
  output logic [CAN_CRC_LEN-1:0] crc_o,
  output logic [CAN_CRC_LEN-1:0] crc_nxt_o
);

  logic [CAN_CRC_LEN-1:0] crc_q;

  always_comb begin
    crc_nxt_o = crc_q;
    if (clr_i)     crc_nxt_o = '0;
    else if (en_i) crc_nxt_o = crc15_step(crc_q, din_i);
  end

  always_ff @(posedge clock) crc_q <= crc_nxt_o;

  assign crc_o = crc_q;

endmodule

// File: rtl/can_crc_sequencer.sv
// Frame-level control of the CAN CRC-15 LFSR: accumulate, serialise/check CRC, check delimiter.
module can_crc_sequencer
  import can_pkg::*;
#(
  parameter int CRC_LEN     = CAN_CRC_LEN,
  parameter bit DELIM_CHECK = 1'b1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               bit_strobe,
  input  logic               bit_in,
  input  logic               stuff_bit,
  input  logic               sof,
  input  logic               crc_start,
  input  logic               tx_mode,
  input  logic               abort,
  output logic               busy,
  output logic [CRC_LEN-1:0] crc_value,
  output logic               tx_crc_bit,
  output logic               crc_done,
  output logic               crc_ok,
  output logic               crc_err,
  output logic               form_err
);

  localparam int CW = $clog2(CRC_LEN + 1);

  crc_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [CRC_LEN-1:0] shadow_q, shadow_d;
  logic [CRC_LEN-1:0] crc_nxt;
  logic               txm_q, txm_d;
  logic               done_q, done_d, ok_q, ok_d, err_q, err_d, ferr_q, ferr_d;
  logic               strobe_ok, sof_hit, crc_clear, lfsr_en;

  assign strobe_ok = bit_strobe & ~stuff_bit;
  assign sof_hit   = strobe_ok & sof;
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    txm_d     = txm_q;
    done_d    = 1'b0;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    ferr_d    = 1'b0;
    crc_clear = 1'b0;
    lfsr_en   = strobe_ok & ((state_q == ST_ACCUM) | ((state_q == ST_CRC_FIELD) & ~txm_q));

    unique case (state_q)
      ST_IDLE: begin
        crc_clear = 1'b1;
        if (sof_hit) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (sof_hit) begin
          crc_clear = 1'b1;
        end else if (crc_start) begin
          // crc_nxt already includes a data bit strobed in this same cycle
          state_d  = ST_CRC_FIELD;
          txm_d    = tx_mode;
          shadow_d = crc_nxt;
          cnt_d    = '0;
        end
      end
      ST_CRC_FIELD: begin
        if (sof_hit) begin
          crc_clear = 1'b1;
          cnt_d     = '0;
          state_d   = ST_ACCUM;
        end else if (strobe_ok) begin
          cnt_d = cnt_inc;
          if (txm_q) shadow_d = {shadow_q[CRC_LEN-2:0], 1'b0};
          if (cnt_inc == CW'(CRC_LEN)) state_d = ST_DELIM;
        end
      end
      ST_DELIM: begin
        // the delimiter is never stuffed, so stuff_bit is not consulted here
        if (bit_strobe) begin
          done_d  = 1'b1;
          ok_d    = ~txm_q & (crc_value == '0);
          err_d   = ~txm_q & (crc_value != '0);
          ferr_d  = DELIM_CHECK & ~bit_in;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d   = ST_IDLE;
      crc_clear = 1'b1;
      lfsr_en   = 1'b0;
      done_d    = 1'b0;
      ok_d      = 1'b0;
      err_d     = 1'b0;
      ferr_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      txm_q    <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      txm_q    <= txm_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      ferr_q   <= ferr_d;
    end
  end

  can_crc u_crc (
    .clock     (clock),
    .clr_i     (crc_clear | ~reset_n),
    .en_i      (lfsr_en),
    .din_i     (bit_in),
    .crc_o     (crc_value),
    .crc_nxt_o (crc_nxt)
  );

  assign busy       = (state_q != ST_IDLE);
  assign tx_crc_bit = (state_q == ST_CRC_FIELD && txm_q) ? shadow_q[CRC_LEN-1] : 1'b1;
  assign crc_done   = done_q;
  assign crc_ok     = ok_q;
  assign crc_err    = err_q;
  assign form_err   = ferr_q;

endmodule

// File: doc/can_crc_sequencer.md
Name: can_crc_sequencer

Overview:
Controller that sequences the CRC-15 LFSR unit (can_crc) across one CAN frame. It clears the LFSR at SOF, gates it with bit strobes and excludes stuff bits. At the CRC field it either serialises the frozen CRC (TX) or checks the received CRC by residue (RX), then checks the CRC delimiter. It sits between the bit-stream/destuff stage and the MAC frame FSM.

Parameters:
CRC_LEN, 15, CRC field length in bits; fixed to match can_crc.
DELIM_CHECK, 1, when 1 a dominant CRC delimiter raises form_err.

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
bit_strobe  in  1  one-cycle pulse per sampled/transmitted bit
bit_in  in  1  current frame bit (TX: bit driven; RX: bit sampled)
stuff_bit  in  1  qualifies bit_strobe: current bit is a stuff bit, excluded from CRC and counters
sof  in  1  with bit_strobe: this bit is SOF, start new frame
crc_start  in  1  one-cycle pulse between last data bit and first CRC bit
tx_mode  in  1  1 = transmit (serialise CRC), 0 = receive (check CRC); sampled at crc_start
abort  in  1  error frame / bus-off: abandon frame
busy  out  1  state != IDLE
crc_value  out  15  live LFSR contents
tx_crc_bit  out  1  next CRC bit to transmit, MSB first; 1 (recessive) when not in CRC phase
crc_done  out  1  pulse: delimiter consumed, frame CRC phase finished
crc_ok  out  1  pulse with crc_done in RX when residue == 0
crc_err  out  1  pulse with crc_done in RX when residue != 0
form_err  out  1  pulse: dominant delimiter (DELIM_CHECK=1)

Behaviour:
- Reset (reset_n=0, async): state IDLE, crc_cnt=0, shadow=0, all pulses 0, tx_crc_bit=1. LFSR held cleared via crc_clear while in IDLE.
- States: IDLE, ACCUM, CRC_FIELD, DELIM.
- LFSR drive (combinational): enable = bit_strobe & ~stuff_bit & (ACCUM | (CRC_FIELD & ~tx_mode_q)). data_in = bit_in. The LFSR updates on the same edge as the strobe.
- IDLE -> ACCUM: on bit_strobe & sof. crc_clear asserted that cycle. The SOF bit (0) into a zero register leaves crc_value = 0.
- ACCUM -> CRC_FIELD: on crc_start. Latch tx_mode_q = tx_mode, shadow = crc_value, crc_cnt = 0.
- CRC_FIELD: on each non-stuff strobe, crc_cnt++. In TX, shadow shifts left and tx_crc_bit = shadow[14]. At crc_cnt reaching CRC_LEN, go to DELIM. In RX the LFSR keeps absorbing the received CRC bits.
- DELIM: the next strobe is the delimiter, and stuff_bit is ignored here. On that strobe:
  - assert crc_done for 1 cycle.
  - RX: crc_ok if crc_value == 0, else crc_err.
  - if bit_in == 0 and DELIM_CHECK: form_err.
  - then go to IDLE.
- Pulses are registered, 1 cycle after the delimiter strobe edge.
- abort has priority over every other input: IDLE next edge, no done/ok/err pulses.
- sof & bit_strobe while busy (outside DELIM): restart, LFSR cleared, state ACCUM.
- crc_start outside ACCUM: ignored.
- A strobe that has stuff_bit=1 changes no state and no counter.
- crc_start with bit_strobe in the same cycle: the strobe bit is accumulated as data first, then the CRC phase begins.

Decomposition:
- Shared package can_pkg: CRC_LEN, state encoding (IDLE/ACCUM/CRC_FIELD/DELIM), CRC poly constant 15'h4599 for bench models.
- One sub-module instance: can_crc (LFSR; sync active-high reset driven by crc_clear | ~reset_n-synchronised idle clear).

Test Plan:
- SOF then RX data bit 1 -> crc_value = 15'h4599. crc_start, then feed 0x4599 MSB first (15 strobes), delimiter 1 -> crc_done and crc_ok pulse, crc_err=0.
- Same as above with one CRC bit flipped -> crc_err pulse, crc_ok=0.
- TX: SOF, data bit 1, crc_start (tx_mode=1) -> tx_crc_bit sequence 1,0,0,0,1,0,1,1,0,0,1,1,0,0,1, then 1 after the field. crc_done on the delimiter.
- Stuff-bit insertion: case 1 with stuff_bit=1 strobes (bit_in random) interleaved in data and CRC field -> identical crc_value and crc_ok.
- Delimiter bit 0 -> form_err pulse alongside crc_done.
- abort mid-CRC_FIELD, and reset_n low mid-frame -> IDLE, busy=0, no done/ok/err pulses. A following normal frame checks correctly.
